dac_spi: RTL
============

# dac_spi

Serial DAC driver downstream of the waveform sample path: it accepts one 12-bit sample per transfer and shifts it out as a 32-bit SPI write frame to the on-board LTC2624-class DAC. It drives `spi_mosi`, `spi_sck`, `dac_cs` and `dac_clr`, the four DAC pins of the `generator` top level. It also generates the post-reset DAC clear pulse and a load/busy/done handshake, so the sample source can be paced by frame completion.

## Interface
- `CLK_DIV`, 2: SCK half-period in `clk` cycles (≥1).
- `CLR_LEN`, 4: `clk` cycles `dac_clr` stays low after reset release (≥1).
- `CMD`, 4'b0011: DAC command nibble (write-and-update).
- `ADDR`, 4'b1111: DAC channel address nibble (all channels).
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `sample`  in  12  DAC code; captured on accepted `load`.
- `load`  in  1  transfer request; accepted only when `busy`=0.
- `busy`  out  1  high in INIT, SHIFT, GAP.
- `done`  out  1  one-cycle pulse when `dac_cs` rises at frame end.
- `spi_mosi`  out  1  serial data, MSB first.
- `spi_sck`  out  1  serial clock, idles low.
- `dac_cs`  out  1  active-low chip select.
- `dac_clr`  out  1  active-low DAC clear.

## Operation
- Frame (32 b, MSB first): [31:24]=8'h00, [23:20]=CMD, [19:16]=ADDR, [15:4]=sample, [3:0]=4'h0.
- States: INIT, IDLE, SHIFT, GAP.
- INIT: entered on reset. `dac_clr`=0. Leaves to IDLE after CLR_LEN cycles counted from the first cycle with `rst`=0. `load` is ignored.
- IDLE: `busy`=0, `dac_cs`=1, `spi_sck`=0.
  - `load`=1 loads the frame into a 32-bit shift register, then goes to SHIFT.
  - `sample` changes after acceptance do not affect the frame in flight.
- SHIFT: `dac_cs`=0.
  - Per bit: SCK low CLK_DIV cycles, then high CLK_DIV cycles.
  - `spi_mosi` changes only while SCK is low, at the start of each bit's low phase. The DAC samples it on the SCK rising edge.
  - A 5-bit bit counter and a divider counter are used. After the high phase of bit 0, go to GAP.
- GAP: `dac_cs`=1, `spi_sck`=0, `done`=1 for the first cycle only. Holds CLK_DIV cycles, then goes to IDLE.
- `load` while `busy`=1 is dropped; there is no queuing.
- `load` held high continuously yields back-to-back frames, each separated by GAP plus one IDLE cycle.

## Timing
- Reset values (cycle after `rst` sampled high): `dac_cs`=1, `spi_sck`=0, `spi_mosi`=0, `dac_clr`=0, `busy`=1, `done`=0.
- Reset mid-frame aborts at once. Outputs take their reset values on the next cycle, including `dac_cs`=1. No `done` pulse is issued.
- Accept at cycle T (`load`=1 sampled in IDLE). At T+1: `dac_cs`=0, `spi_mosi`=bit31, `spi_sck`=0.
- First SCK rise at T+1+CLK_DIV. `dac_cs` is low for exactly 64·CLK_DIV cycles.
- At T+1+64·CLK_DIV: `dac_cs`=1, `done`=1.
- `busy` falls at T+1+65·CLK_DIV. The earliest next accept is that cycle.
- Outputs are registered; there are no combinational paths from inputs to pins.
- Exactly 32 SCK rising edges per frame. `spi_mosi` is stable ≥CLK_DIV cycles before and after each rise, except after the last rise, where it is don't-care.

## Test plan
- Reset release, CLR_LEN=4: `dac_clr` stays low exactly 4 cycles after `rst` drops; `busy`=1 throughout; `load` pulsed during INIT is ignored (`dac_cs` stays 1).
- `sample`=12'hABC, defaults: bits captured on SCK rises = 32'h003FABC0. `dac_cs` low 128 cycles, 32 SCK rises, one `done` pulse as `dac_cs` rises.
- `load` pulsed mid-frame and `sample` changed to 12'h123 mid-frame: only one frame is sent, and it still carries 0xABC.
- `load` held high for 3 frames, `sample`=12'h000/12'hFFF/12'h555: three frames 32'h003F0000, 32'h003FFFF0, 32'h003F5550; `dac_cs` high for exactly CLK_DIV+1 cycles between frames.
- `rst` asserted at bit 10 of a frame: next cycle `dac_cs`=1, `spi_sck`=0, no `done`; INIT/clear sequence repeats; a following frame is correct.
- CLK_DIV=1 build: `dac_cs` low 64 cycles, SCK toggles every cycle, frame content correct.

Source files
------------

// File: rtl/dac_spi_if.sv
// Sample-source side of the DAC driver: one 12-bit code per load, paced by busy/done.
interface dac_spi_if;
  logic [11:0] sample;
  logic        load;
  logic        busy;
  logic        done;

  modport master (output sample, load, input  busy, done);
  modport slave  (input  sample, load, output busy, done);
endinterface

// File: rtl/dac_spi.sv
// Shifts one 12-bit code per load out as a 32-bit SPI write frame to an LTC2624-class DAC; cs falls one cycle after accept.
// No queuing: load is only honoured in IDLE (busy=0), requests while busy are dropped; all pins are registered.
module dac_spi #(
  parameter int         CLK_DIV = 2,
  parameter int         CLR_LEN = 4,
  parameter logic [3:0] CMD     = 4'b0011,
  parameter logic [3:0] ADDR    = 4'b1111
) (
  input  logic      clk,
  input  logic      rst,
  dac_spi_if.slave  host,
  output logic      spi_mosi,
  output logic      spi_sck,
  output logic      dac_cs,
  output logic      dac_clr
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CW = (CLR_LEN > 1) ? $clog2(CLR_LEN) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CLR_LAST = CW'(CLR_LEN - 1);

  typedef enum logic [1:0] {INIT, IDLE, SHIFT, GAP} state_t;

  state_t        state, state_n;
  logic [CW-1:0] clr_cnt, clr_cnt_n;
  logic [DW-1:0] div_cnt, div_cnt_n;
  logic [4:0]    bit_cnt, bit_cnt_n;
  logic [31:0]   shreg, shreg_n;
  logic [31:0]   frame;
  logic          mosi_q, mosi_n;
  logic          sck_q, sck_n;
  logic          cs_q, cs_n;
  logic          clr_q, clr_n;
  logic          busy_q, busy_n;
  logic          done_q, done_n;

  assign frame = {8'h00, CMD, ADDR, host.sample, 4'h0};

  always_comb begin
    state_n   = state;
    clr_cnt_n = clr_cnt;
    div_cnt_n = div_cnt;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    mosi_n    = mosi_q;
    sck_n     = sck_q;
    cs_n      = cs_q;
    clr_n     = clr_q;
    busy_n    = busy_q;
    done_n    = 1'b0;
    unique case (state)
      INIT: begin
        if (clr_cnt == CLR_LAST) begin
          state_n = IDLE;
          clr_n   = 1'b1;
          busy_n  = 1'b0;
        end else begin
          clr_cnt_n = clr_cnt + 1'b1;
        end
      end
      IDLE: begin
        if (host.load) begin
          // bit 31 goes straight to the pin; the register holds what follows it
          state_n   = SHIFT;
          shreg_n   = {frame[30:0], 1'b0};
          mosi_n    = frame[31];
          cs_n      = 1'b0;
          sck_n     = 1'b0;
          div_cnt_n = '0;
          bit_cnt_n = 5'd31;
          busy_n    = 1'b1;
        end
      end
      SHIFT: begin
        if (div_cnt == DIV_LAST) begin
          div_cnt_n = '0;
          if (!sck_q) begin
            sck_n = 1'b1;
          end else if (bit_cnt == 5'd0) begin
            state_n = GAP;
            cs_n    = 1'b1;
            sck_n   = 1'b0;
            done_n  = 1'b1;
          end else begin
            // new data bit presented together with the falling SCK edge
            sck_n     = 1'b0;
            bit_cnt_n = bit_cnt - 1'b1;
            mosi_n    = shreg[31];
            shreg_n   = {shreg[30:0], 1'b0};
          end
        end else begin
          div_cnt_n = div_cnt + 1'b1;
        end
      end
      GAP: begin
        if (div_cnt == DIV_LAST) begin
          state_n   = IDLE;
          div_cnt_n = '0;
          busy_n    = 1'b0;
        end else begin
          div_cnt_n = div_cnt + 1'b1;
        end
      end
      default: state_n = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= INIT;
      clr_cnt <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      mosi_q  <= 1'b0;
      sck_q   <= 1'b0;
      cs_q    <= 1'b1;
      clr_q   <= 1'b0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      clr_cnt <= clr_cnt_n;
      div_cnt <= div_cnt_n;
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
      mosi_q  <= mosi_n;
      sck_q   <= sck_n;
      cs_q    <= cs_n;
      clr_q   <= clr_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
    end
  end

  assign spi_mosi  = mosi_q;
  assign spi_sck   = sck_q;
  assign dac_cs    = cs_q;
  assign dac_clr   = clr_q;
  assign host.busy = busy_q;
  assign host.done = done_q;

endmodule
